// File: rtl/risc16_pkg.sv
// Shared types and encodings for the RiSC-16 multicycle control unit.
package risc16_pkg;

    localparam int unsigned XLEN    = 16;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned IMM7_W  = 7;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned OPC_LSB = XLEN - OPC_W;
    localparam int unsigned OPC_MSB = XLEN - 1;

    localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_ADDI = 3'b001;
    localparam logic [OPC_W-1:0] OP_NAND = 3'b010;
    localparam logic [OPC_W-1:0] OP_LUI  = 3'b011;
    localparam logic [OPC_W-1:0] OP_LW   = 3'b100;
    localparam logic [OPC_W-1:0] OP_SW   = 3'b101;
    localparam logic [OPC_W-1:0] OP_BEQ  = 3'b110;
    localparam logic [OPC_W-1:0] OP_JALR = 3'b111;

    typedef enum logic [2:0] {
        RST_IDLE = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MEM      = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TGT_MEM = 2'b00,
        TGT_ALU = 2'b01,
        TGT_PC1 = 2'b10
    } mux_tgt_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_NAND = 2'b01,
        ALU_LUI  = 2'b10,
        ALU_CMP  = 2'b11
    } alu_func_e;

    typedef enum logic [1:0] {
        NPC_INC  = 2'b00,
        NPC_BR   = 2'b01,
        NPC_JALR = 2'b10
    } npc_sel_e;

    // ALU operation required by each opcode; memory ops use add for address generation.
    function automatic alu_func_e alu_func_of(input logic [OPC_W-1:0] op);
        alu_func_e f;
        case (op)
            OP_NAND: f = ALU_NAND;
            OP_LUI:  f = ALU_LUI;
            OP_BEQ:  f = ALU_CMP;
            default: f = ALU_ADD;
        endcase
        return f;
    endfunction

    // sw and beq need rA on the second read port instead of rC.
    function automatic logic reads_ra(input logic [OPC_W-1:0] op);
        return (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/risc16_next_pc.sv
// Next program counter selection: pc+1, beq target (pc+1+sext(imm7)) or jalr target.
module risc16_next_pc
    import risc16_pkg::*;
(
    input  logic [XLEN-1:0]   pc,
    input  logic [IMM7_W-1:0] imm7,
    input  logic [XLEN-1:0]   reg_b_val,
    input  npc_sel_e          sel,
    output logic [XLEN-1:0]   next_pc_c
);

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] imm_sext;

    assign pc_inc   = pc + XLEN'(1);
    assign imm_sext = {{(XLEN - IMM7_W){imm7[IMM7_W-1]}}, imm7};

    always_comb begin
        next_pc_c = pc_inc;
        case (sel)
            NPC_BR:   next_pc_c = pc_inc + imm_sext;
            NPC_JALR: next_pc_c = reg_b_val;
            default:  next_pc_c = pc_inc;
        endcase
    end

endmodule

// File: rtl/risc16_ctrl_fsm.sv
// Multicycle control unit: fetch/decode/exec/mem/wb sequencing, control strobes and PC.
// Optional performance counters are built when RISC16_PERF_CNT_EN is defined.
module risc16_ctrl_fsm
    import risc16_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC         = 16'h0000,
    parameter bit              HALT_ON_JALR_IMM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             alu_eq,
    input  logic [XLEN-1:0]  reg_b_val,
    output logic [XLEN-1:0]  instruction,
    output logic [XLEN-1:0]  pc,
    output logic             WE_rf,
    output logic [1:0]       MUX_tgt,
    output logic             MUX_rf,
    output logic [1:0]       alu_func,
`ifdef RISC16_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic             halted
);

    state_e            state;
    state_e            state_d;
    logic [XLEN-1:0]   instr_d;
    logic [XLEN-1:0]   pc_d;
    logic [OPC_W-1:0]  op;
    logic [OPC_W-1:0]  op_d;
    logic [IMM7_W-1:0] imm7;
    npc_sel_e          npc_sel;
    logic [XLEN-1:0]   next_pc_c;

    logic              mem_req_d;
    logic              mem_we_d;
    logic              mem_addr_sel_d;
    logic              we_rf_d;
    mux_tgt_e          mux_tgt_d;
    logic              mux_rf_d;
    alu_func_e         alu_func_d;
    logic              halted_d;

    // The ALU result is consumed by the datapath address mux, not by the control unit.
    logic unused_alu_out;
    assign unused_alu_out = ^alu_out;

    assign op   = instruction[OPC_MSB:OPC_LSB];
    assign imm7 = instruction[IMM7_W-1:0];

    always_comb begin
        npc_sel = NPC_INC;
        if (op == OP_JALR) begin
            npc_sel = NPC_JALR;
        end else if ((op == OP_BEQ) && alu_eq) begin
            npc_sel = NPC_BR;
        end
    end

    risc16_next_pc u_next_pc (
        .pc        (pc),
        .imm7      (imm7),
        .reg_b_val (reg_b_val),
        .sel       (npc_sel),
        .next_pc_c (next_pc_c)
    );

    // Next state, next instruction/pc and the Moore outputs of the upcoming state.
    always_comb begin
        state_d        = state;
        instr_d        = instruction;
        pc_d           = pc;
        op_d           = '0;
        mem_req_d      = 1'b0;
        mem_we_d       = 1'b0;
        mem_addr_sel_d = 1'b0;
        we_rf_d        = 1'b0;
        mux_tgt_d      = TGT_MEM;
        mux_rf_d       = 1'b0;
        alu_func_d     = ALU_ADD;
        halted_d       = 1'b0;

        case (state)
            RST_IDLE: state_d = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEM;
                    OP_BEQ: begin
                        pc_d    = next_pc_c;
                        state_d = FETCH;
                    end
                    OP_JALR: begin
                        pc_d    = next_pc_c;
                        state_d = (HALT_ON_JALR_IMM && (imm7 != '0)) ? HALT : FETCH;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    if (op == OP_SW) begin
                        pc_d    = next_pc_c;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                pc_d    = next_pc_c;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = RST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        op_d = instr_d[OPC_MSB:OPC_LSB];
        case (state_d)
            FETCH: mem_req_d = 1'b1;
            DECODE: mux_rf_d = reads_ra(op_d);
            EXEC: begin
                mux_rf_d   = reads_ra(op_d);
                alu_func_d = alu_func_of(op_d);
                if (op_d == OP_JALR) begin
                    we_rf_d   = 1'b1;
                    mux_tgt_d = TGT_PC1;
                end
            end
            MEM: begin
                mem_req_d      = 1'b1;
                mem_addr_sel_d = 1'b1;
                mem_we_d       = (op_d == OP_SW);
                mux_rf_d       = reads_ra(op_d);
                alu_func_d     = alu_func_of(op_d);
            end
            WB: begin
                we_rf_d    = 1'b1;
                mux_tgt_d  = (op_d == OP_LW) ? TGT_MEM : TGT_ALU;
                mux_rf_d   = reads_ra(op_d);
                alu_func_d = alu_func_of(op_d);
            end
            HALT:    halted_d = 1'b1;
            default: halted_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RST_IDLE;
            pc           <= RESET_PC;
            instruction  <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            WE_rf        <= 1'b0;
            MUX_tgt      <= 2'b00;
            MUX_rf       <= 1'b0;
            alu_func     <= 2'b00;
            halted       <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            instruction  <= instr_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            mem_addr_sel <= mem_addr_sel_d;
            WE_rf        <= we_rf_d;
            MUX_tgt      <= mux_tgt_d;
            MUX_rf       <= mux_rf_d;
            alu_func     <= alu_func_d;
            halted       <= halted_d;
        end
    end

`ifdef RISC16_PERF_CNT_EN
    // An instruction retires when control returns to FETCH from EXEC, MEM or WB.
    logic retire;
    assign retire = ((state == EXEC) || (state == MEM) || (state == WB)) && (state_d == FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if ((state != RST_IDLE) && (state != HALT)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Directed bench for risc16_ctrl_fsm: one instruction at a time against a bench-driven memory.
module tb_risc16_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] alu_out = 16'h0;
    logic        alu_eq = 1'b0;
    logic [15:0] reg_b_val = 16'h0;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic        WE_rf;
    logic [1:0]  MUX_tgt;
    logic        MUX_rf;
    logic [1:0]  alu_func;
    logic        halted;
`ifdef RISC16_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         cycles;
        int         we_cnt;
        int         we_at;
        logic [1:0] we_tgt;
        logic [1:0] we_alu;
        int         mreq;
        logic       mwe;
        logic       mrf;
    } res_t;

    risc16_ctrl_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .alu_out      (alu_out),
        .alu_eq       (alu_eq),
        .reg_b_val    (reg_b_val),
        .instruction  (instruction),
        .pc           (pc),
        .WE_rf        (WE_rf),
        .MUX_tgt      (MUX_tgt),
        .MUX_rf       (MUX_rf),
        .alu_func     (alu_func),
`ifdef RISC16_PERF_CNT_EN
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt),
`endif
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the next FETCH or on HALT.
    task automatic run_instr(input string tag, input logic [15:0] instr, input int fwait,
                             input int mwait, input logic eq, input logic [15:0] rb,
                             output res_t r);
        int fcnt = 0;
        int mcnt = 0;
        bit done = 0;
        r = '{default: 0};
        alu_eq    = eq;
        reg_b_val = rb;
        while (!done) begin
            if (WE_rf) begin
                r.we_cnt++;
                r.we_at  = r.cycles + 1;
                r.we_tgt = MUX_tgt;
                r.we_alu = alu_func;
            end
            if (mem_req && mem_addr_sel) begin
                r.mreq++;
                if (mem_we) r.mwe = 1'b1;
                r.mrf = MUX_rf;
            end
            mem_ack   = 1'b0;
            mem_rdata = 16'h0;
            if (mem_req && !mem_addr_sel) begin
                mem_rdata = instr;
                mem_ack   = (fcnt == fwait);
                fcnt++;
            end else if (mem_req) begin
                mem_ack = (mcnt == mwait);
                mcnt++;
            end
            @(negedge clk);
            r.cycles++;
            if (((fcnt > fwait) && mem_req && !mem_addr_sel) || halted) begin
                done = 1;
            end else if (r.cycles >= 40) begin
                check({tag, "_timeout"}, 32'(done), 32'd1);
                done = 1;
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        res_t r;
        int   bad;

        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_instr", 32'(instruction), 32'h0000);
        check("rst_strobes", 32'({mem_req, mem_we, mem_addr_sel, WE_rf, MUX_rf, halted}), 32'd0);
        check("rst_mux_alu", 32'({MUX_tgt, alu_func}), 32'd0);
        rst = 1'b0;
        check("idle_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("fetch_req_cycle1", 32'(mem_req), 32'd1);

        // addi r1,r0,5
        run_instr("addi", 16'h2405, 0, 0, 1'b0, 16'h0, r);
        check("addi_cycles", 32'(r.cycles), 32'd4);
        check("addi_we_at", 32'(r.we_at), 32'd4);
        check("addi_we_cnt", 32'(r.we_cnt), 32'd1);
        check("addi_tgt", 32'(r.we_tgt), 32'd1);
        check("addi_pc", 32'(pc), 32'h0001);
        check("addi_instr", 32'(instruction), 32'h2405);

        // add r1,r2,r3 with a 2-cycle fetch wait
        run_instr("add_wait", 16'h0503, 2, 0, 1'b0, 16'h0, r);
        check("add_wait_cycles", 32'(r.cycles), 32'd6);
        check("add_wait_pc", 32'(pc), 32'h0002);

        // nand r1,r2,r3
        run_instr("nand", 16'h4503, 0, 0, 1'b0, 16'h0, r);
        check("nand_alu", 32'(r.we_alu), 32'd1);
        check("nand_pc", 32'(pc), 32'h0003);

        // jalr r7,r2 to 0x0010, then beq r1,r1,-2 taken
        run_instr("jalr_10", 16'hFD00, 0, 0, 1'b0, 16'h0010, r);
        check("jalr_10_cycles", 32'(r.cycles), 32'd3);
        check("jalr_10_pc", 32'(pc), 32'h0010);
        run_instr("beq_t", 16'hC4FE, 0, 0, 1'b1, 16'h0, r);
        check("beq_t_cycles", 32'(r.cycles), 32'd3);
        check("beq_t_we", 32'(r.we_cnt), 32'd0);
        check("beq_t_pc", 32'(pc), 32'h000F);

        // same beq at 0x0010, not taken
        run_instr("jalr_10b", 16'hFD00, 0, 0, 1'b0, 16'h0010, r);
        run_instr("beq_nt", 16'hC4FE, 0, 0, 1'b0, 16'h0, r);
        check("beq_nt_we", 32'(r.we_cnt), 32'd0);
        check("beq_nt_pc", 32'(pc), 32'h0011);

        // lw r1,r2,3 with MEM ack delayed 3 cycles
        run_instr("lw", 16'h8503, 0, 3, 1'b0, 16'h0, r);
        check("lw_cycles", 32'(r.cycles), 32'd8);
        check("lw_mreq", 32'(r.mreq), 32'd4);
        check("lw_mwe", 32'(r.mwe), 32'd0);
        check("lw_mrf", 32'(r.mrf), 32'd0);
        check("lw_tgt", 32'(r.we_tgt), 32'd0);
        check("lw_pc", 32'(pc), 32'h0012);

        // sw r1,r2,3
        run_instr("sw", 16'hA503, 0, 0, 1'b0, 16'h0, r);
        check("sw_cycles", 32'(r.cycles), 32'd4);
        check("sw_mwe", 32'(r.mwe), 32'd1);
        check("sw_mrf", 32'(r.mrf), 32'd1);
        check("sw_we", 32'(r.we_cnt), 32'd0);
        check("sw_pc", 32'(pc), 32'h0013);

        // jalr r7,r2 at 0x00FF to 0x1234
        run_instr("jalr_ff", 16'hFD00, 0, 0, 1'b0, 16'h00FF, r);
        run_instr("jalr", 16'hFD00, 0, 0, 1'b0, 16'h1234, r);
        check("jalr_we", 32'(r.we_cnt), 32'd1);
        check("jalr_tgt", 32'(r.we_tgt), 32'd2);
        check("jalr_pc", 32'(pc), 32'h1234);

        // addi at 0xFFFF wraps
        run_instr("jalr_ffff", 16'hFD00, 0, 0, 1'b0, 16'hFFFF, r);
        run_instr("addi_wrap", 16'h2405, 0, 0, 1'b0, 16'h0, r);
        check("wrap_pc", 32'(pc), 32'h0000);

        // jalr with imm7 = 1 halts after completing
        run_instr("jalr_halt", 16'hFD01, 0, 0, 1'b0, 16'h2000, r);
        check("halt_cycles", 32'(r.cycles), 32'd3);
        check("halt_we", 32'(r.we_cnt), 32'd1);
        check("halt_pc", 32'(pc), 32'h2000);
        bad = 0;
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req || !halted) bad++;
        end
        mem_ack = 1'b0;
        check("halt_stays", 32'(bad), 32'd0);
        check("halt_flag", 32'(halted), 32'd1);

        // rst while FETCH waits for ack
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_instr("addi_post", 16'h2405, 0, 0, 1'b0, 16'h0, r);
        check("post_pc", 32'(pc), 32'h0001);
        repeat (2) @(negedge clk);
        check("fetch_held", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_pc", 32'(pc), 32'h0000);
        check("midrst_instr", 32'(instruction), 32'h0000);
        check("midrst_we", 32'(WE_rf), 32'd0);
`ifdef RISC16_PERF_CNT_EN
        check("midrst_cycle_cnt", cycle_cnt, 32'd0);
        check("midrst_instret_cnt", instret_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
